// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, reset PC and the
// {PC, instruction} record carried from fetch to decode.
package cpu_pkg;

    localparam int XLEN = 32;

    // Also used by the PC stage as its reset vector.
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Saturating increment for 16-bit event monitors.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/if_queue_if.sv
// Fetch-queue port bundle: the fetch/decode side drives push, pop and
// flush (master); the queue answers with flags, head entry and monitors (slave).
interface if_queue_if #(
    parameter int DEPTH = 4
);
    import cpu_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic            push;
    logic [XLEN-1:0] push_pc;
    logic [XLEN-1:0] push_instr;
    logic            full;
    logic            pop;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            flush;
    logic [AW:0]     count;
    logic [15:0]     drop_cnt;

    modport master (
        output push, push_pc, push_instr, pop, flush,
        input  full, out_valid, out_pc, out_instr, count, drop_cnt
    );

    modport slave (
        input  push, push_pc, push_instr, pop, flush,
        output full, out_valid, out_pc, out_instr, count, drop_cnt
    );

endinterface

// File: rtl/if_queue_mem.sv
// Entry storage for the fetch queue: DEPTH registers of one fetch record,
// written on the clock edge, read combinationally, cleared by reset.
module if_queue_mem
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         Clk,
    input  logic         Clrn,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t rdata
);

    fetch_entry_t entries [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t entry_reg;

            // One slot: load when the write pointer selects it.
            always_ff @(posedge Clk or negedge Clrn) begin
                if (!Clrn) begin
                    entry_reg <= '0;
                end else if (we && (waddr == AW'(gi))) begin
                    entry_reg <= wdata;
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

    // DEPTH is a power of two, so every raddr value selects a real slot.
    assign rdata = entries[raddr];

endmodule

// File: rtl/if_queue.sv
// Instruction fetch queue between the PC stage and decode.
// Circular buffer with separate count; full feeds the PC stall, flush
// (redirect) empties the queue, drop_cnt counts pushes rejected while full.
// Optional build macro IF_QUEUE_BYPASS_EN: when the queue is empty an
// incoming push is shown at the outputs in the same cycle, and consumed
// without being stored if decode pops it at once.
module if_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic Clk,
    input  logic Clrn,
    if_queue_if.slave q
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic [15:0]   drop_cnt_reg, drop_cnt_next;

    logic full_w;
    logic stored_valid_w;
    logic out_valid_w;
    logic bypass_w;
    logic push_acc_w;
    logic pop_acc_w;
    logic bypass_take_w;
    logic do_write_w;
    logic do_read_w;
    logic drop_w;

    fetch_entry_t wr_entry_w;
    fetch_entry_t head_w;

    // Flags come from the registered count only, so full never depends
    // on this cycle's push/pop and the PC stall path stays short.
    assign full_w         = (count_reg == FULL_COUNT);
    assign stored_valid_w = (count_reg != '0);

`ifdef IF_QUEUE_BYPASS_EN
    assign bypass_w = (count_reg == '0) && q.push && !q.flush;
`else
    assign bypass_w = 1'b0;
`endif

    assign out_valid_w = stored_valid_w || bypass_w;

    // Acceptance rules; flush wins over both push and pop.
    assign push_acc_w    = q.push && !full_w && !q.flush;
    assign pop_acc_w     = q.pop && out_valid_w && !q.flush;
    assign drop_w        = q.push && full_w && !q.flush;

    // A bypassed entry popped in the same cycle never touches storage.
    assign bypass_take_w = bypass_w && q.pop;
    assign do_write_w    = push_acc_w && !bypass_take_w;
    assign do_read_w     = pop_acc_w && !bypass_take_w;

    assign wr_entry_w.pc    = q.push_pc;
    assign wr_entry_w.instr = q.push_instr;

    if_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .Clk   (Clk),
        .Clrn  (Clrn),
        .we    (do_write_w),
        .waddr (wr_ptr_reg),
        .wdata (wr_entry_w),
        .raddr (rd_ptr_reg),
        .rdata (head_w)
    );

    // Next pointer, occupancy and drop-monitor values.
    always_comb begin
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        drop_cnt_next = drop_cnt_reg;

        if (q.flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_write_w) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (do_read_w) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            case ({do_write_w, do_read_w})
                2'b10:   count_next = count_reg + COUNT_ONE;
                2'b01:   count_next = count_reg - COUNT_ONE;
                default: count_next = count_reg;
            endcase
            if (drop_w) begin
                drop_cnt_next = sat_inc16(drop_cnt_reg);
            end
        end
    end

    // State registers; reset empties the queue immediately.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            drop_cnt_reg <= '0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    assign q.full      = full_w;
    assign q.out_valid = out_valid_w;
    assign q.out_pc    = bypass_w ? q.push_pc    : head_w.pc;
    assign q.out_instr = bypass_w ? q.push_instr : head_w.instr;
    assign q.count     = count_reg;
    assign q.drop_cnt  = drop_cnt_reg;

endmodule
